// File: rtl/rms_denorm.sv
// rtl/rms_denorm.sv - element-wise vector x scalar de-normalizer with saturation
// Multiplies LANES elements per enabled cycle; a start on the completion edge chains the next vector.
module rms_denorm #(
  parameter int ARR_WIDTH = 8,
  parameter int FXP_N     = 16,
  parameter int FXP_Q     = 8,
  parameter int LANES     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         start,
  input  logic [ARR_WIDTH*FXP_N-1:0]   input_arr,
  input  logic signed [FXP_N-1:0]      rms_in,
  output logic [ARR_WIDTH*FXP_N-1:0]   output_arr,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf
);

  localparam int CHUNKS = ARR_WIDTH / LANES;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int EL_W   = (ARR_WIDTH > 1) ? $clog2(ARR_WIDTH) : 1;
  localparam int PW     = 2 * FXP_N;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);
  localparam logic signed [PW-1:0] SAT_MAX = {{(FXP_N+1){1'b0}}, {(FXP_N-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(FXP_N+1){1'b1}}, {(FXP_N-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [FXP_N-1:0]  x_q [ARR_WIDTH];
  logic signed [FXP_N-1:0]  x_d [ARR_WIDTH];
  logic signed [FXP_N-1:0]  rms_q, rms_d;
  logic signed [FXP_N-1:0]  work_q [ARR_WIDTH];
  logic signed [FXP_N-1:0]  work_d [ARR_WIDTH];
  logic signed [FXP_N-1:0]  work_next [ARR_WIDTH];
  logic signed [FXP_N-1:0]  out_q [ARR_WIDTH];
  logic signed [FXP_N-1:0]  out_d [ARR_WIDTH];
  logic                     work_ovf_q, work_ovf_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;

  logic                     last_chunk;
  logic                     accept;
  logic                     lane_ovf;
  logic [EL_W-1:0]          elem;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     shifted;

  assign last_chunk = (idx_q == LAST_IDX);
  assign accept     = enable && start && ((state_q == S_IDLE) || last_chunk);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_RUN;
        S_RUN:   if (last_chunk && !start) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // output logic
  always_comb begin
    busy       = (state_q == S_RUN);
    done       = done_q;
    ovf        = ovf_q;
    output_arr = '0;
    for (int i = 0; i < ARR_WIDTH; i++) begin
      output_arr[i*FXP_N +: FXP_N] = out_q[i];
    end
  end

  // lane multipliers: floor-shift then clamp to the signed element range
  always_comb begin
    work_next = work_q;
    lane_ovf  = 1'b0;
    elem      = '0;
    prod      = '0;
    shifted   = '0;
    for (int l = 0; l < LANES; l++) begin
      elem    = EL_W'(int'(idx_q) * LANES + l);
      prod    = PW'(x_q[elem]) * PW'(rms_q);
      shifted = prod >>> FXP_Q;
      if (shifted > SAT_MAX) begin
        work_next[elem] = SAT_MAX[FXP_N-1:0];
        lane_ovf        = 1'b1;
      end else if (shifted < SAT_MIN) begin
        work_next[elem] = SAT_MIN[FXP_N-1:0];
        lane_ovf        = 1'b1;
      end else begin
        work_next[elem] = shifted[FXP_N-1:0];
      end
    end
  end

  always_comb begin
    x_d        = x_q;
    rms_d      = rms_q;
    idx_d      = idx_q;
    work_d     = work_q;
    work_ovf_d = work_ovf_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    done_d     = done_q;
    if (enable) begin
      done_d = 1'b0;
      if (state_q == S_RUN) begin
        work_d     = work_next;
        work_ovf_d = work_ovf_q | lane_ovf;
        idx_d      = idx_q + IDX_W'(1);
        if (last_chunk) begin
          out_d  = work_next;
          ovf_d  = work_ovf_q | lane_ovf;
          done_d = 1'b1;
          idx_d  = '0;
        end
      end
      if (accept) begin
        for (int i = 0; i < ARR_WIDTH; i++) begin
          x_d[i] = input_arr[i*FXP_N +: FXP_N];
        end
        rms_d      = rms_in;
        idx_d      = '0;
        work_ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      rms_q      <= '0;
      work_ovf_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < ARR_WIDTH; i++) begin
        x_q[i]    <= '0;
        work_q[i] <= '0;
        out_q[i]  <= '0;
      end
    end else begin
      idx_q      <= idx_d;
      rms_q      <= rms_d;
      work_ovf_q <= work_ovf_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      x_q        <= x_d;
      work_q     <= work_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: tb/tb_rms_denorm.sv
// tb/tb_rms_denorm.sv - scoreboard bench for rms_denorm
// Stimulus pushes expected results; a negedge monitor checks each done pulse.
module tb_rms_denorm;

  localparam int N = 16;
  localparam int A = 8;
  localparam int W = A * N;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic                start;
  logic [W-1:0]        input_arr;
  logic signed [N-1:0] rms_in;
  logic [W-1:0]        output_arr;
  logic                busy;
  logic                done;
  logic                ovf;

  typedef struct {
    logic [W-1:0] arr;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  rms_denorm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .start      (start),
    .input_arr  (input_arr),
    .rms_in     (rms_in),
    .output_arr (output_arr),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] pk(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7);
    return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [W-1:0] ev, input logic eo, input int at);
    exp_t e;
    e.arr = ev;
    e.ovf = eo;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // called at a negedge: accept happens on the next posedge, done is seen 5 negedges later
  task automatic drive(input logic [W-1:0] v, input logic signed [N-1:0] r,
                       input logic [W-1:0] ev, input logic eo, input int stalls);
    input_arr = v;
    rms_in    = r;
    start     = 1'b1;
    push_exp(ev, eo, cyc + 5 + stalls);
  endtask

  task automatic run_one(input logic [W-1:0] v, input logic signed [N-1:0] r,
                         input logic [W-1:0] ev, input logic eo);
    drive(v, r, ev, eo, 0);
    tick(1);
    start = 1'b0;
    tick(6);
  endtask

  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !done_prev) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("output_arr", output_arr, e.arr);
          check("ovf", W'(ovf), W'(e.ovf));
          check("done_cycle", W'(cyc), W'(e.cyc));
        end
      end
      done_prev = done;
    end
  end

  initial begin : stim
    logic [W-1:0] va, ea, vs, es, vi, vt, et, vn, en;
    va = pk(256, -128, 0, 64, 512, -256, 1, -1);
    ea = pk(512, -256, 0, 128, 1024, -512, 2, -2);
    vs = pk(32767, -32768, 100, -100, 0, 0, 0, 0);
    es = pk(32767, -32768, 200, -200, 0, 0, 0, 0);
    vi = pk(1000, -1000, 3, -3, 7, 0, -7, 32767);
    vt = pk(-1, 1, 3, -3, 255, -255, 256, -256);
    et = pk(-1, 0, 0, -1, 0, -1, 1, -1);
    vn = pk(100, -100, 32767, -32768, 0, 1, -1, 12345);
    en = pk(-100, 100, -32767, 32767, 0, -1, 1, -12345);

    rst_n = 1'b0; enable = 1'b1; start = 1'b0; input_arr = '0; rms_in = '0;
    tick(2);
    check("reset_output_arr", output_arr, '0);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_ovf", W'(ovf), '0);
    rst_n = 1'b1;
    tick(1);

    // basic scale with busy window
    drive(va, 16'sd512, ea, 1'b0, 0);
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("busy_running", W'(busy), W'(1));
      tick(1);
    end
    check("busy_after_done", W'(busy), '0);
    tick(2);

    run_one(vs, 16'sd512, es, 1'b1);
    run_one(vi, 16'sd256, vi, 1'b0);
    run_one(vt, 16'sd1, et, 1'b0);
    run_one(vn, -16'sd256, en, 1'b1);

    // stall, input change after accept, start while busy
    drive(va, 16'sd512, ea, 1'b0, 3);
    tick(1);
    start = 1'b0; input_arr = ~va; rms_in = 16'sd7;
    tick(1);
    enable = 1'b0;
    tick(1);
    check("busy_stalled", W'(busy), W'(1));
    tick(2);
    enable = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);

    // back-to-back with start held high
    drive(va, 16'sd512, ea, 1'b0, 0);
    tick(1);
    input_arr = vs; rms_in = 16'sd512;
    push_exp(es, 1'b1, cyc + 8);
    tick(4);
    start = 1'b0;
    tick(7);

    // reset while idx = 2
    input_arr = va; rms_in = 16'sd512; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    check("midreset_output_arr", output_arr, '0);
    check("midreset_busy", W'(busy), '0);
    check("midreset_done", W'(done), '0);
    check("midreset_ovf", W'(ovf), '0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    run_one(va, 16'sd512, ea, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    check("pending_results", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
